bexkat1_bus_arbiter: RTL and testbench

//  Shares one Wishbone-style slave port (memory/IO fabric) between two bexkat1 bus masters:
//  m0 = bexkat1 CPU, m1 = DMA/second core. Round-robin grant, bus lock for a whole cyc tenure,
//  and a watchdog that terminates stalled cycles with an error strobe.

---
 rtl/bexkat1_bus_arbiter.sv | 80 ++++++++
 tb/tb_bexkat1_bus_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bexkat1_bus_arbiter.sv
// bexkat1_bus_arbiter: two-master round-robin Wishbone arbiter with tenure lock and stall watchdog
module bexkat1_bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state;
  logic owner, last, tpulse, cyc, busy, fire, pick;
  logic [W-1:0] wdog;
  assign cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign busy = state == BUSY;
  assign fire = TIMEOUT > 0 && busy && cyc && !s_ack_i && wdog == W'(TIMEOUT - 1);
  // on a tie the master that did not win last time gets the bus
  assign pick = (m0_cyc_i && m1_cyc_i) ? ~last : m1_cyc_i;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      wdog <= '0;
      tpulse <= 1'b0;
    end else begin
      tpulse <= fire;
      case (state)
        IDLE: if (m0_cyc_i || m1_cyc_i) begin
          owner <= pick;
          last <= pick;
          wdog <= '0;
          state <= BUSY;
        end
        BUSY: if (!cyc) state <= IDLE;
          else if (fire) state <= ERR;
          else wdog <= s_ack_i ? '0 : (wdog == '1 ? wdog : wdog + 1'b1);
        ERR: if (!cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign s_cyc_o = busy && cyc;
  assign s_we_o = busy && (owner ? m1_we_i : m0_we_i);
  assign s_adr_o = busy ? (owner ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = busy ? (owner ? m1_dat_i : m0_dat_i) : '0;
  assign s_sel_o = busy ? (owner ? m1_sel_i : m0_sel_i) : '0;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = busy && !owner && m0_cyc_i && s_ack_i;
  assign m1_ack_o = busy && owner && m1_cyc_i && s_ack_i;
  assign m0_err_o = tpulse && !owner;
  assign m1_err_o = tpulse && owner;
  assign timeout_o = tpulse;
  assign grant_o = (busy || state == ERR) ? (owner ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_bexkat1_bus_arbiter.sv
// tb_bexkat1_bus_arbiter: directed vector table plus hand-written lock, watchdog and reset sequences
module tb_bexkat1_bus_arbiter;
  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2000;
  localparam logic [31:0] D0 = 32'hA0A0_A0A0, D1 = 32'hB1B1_B1B1;
  localparam logic [3:0] S0 = 4'hF, S1 = 4'h6;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic m0_cyc_i = 1'b0, m1_cyc_i = 1'b0, s_ack_i = 1'b0;
  logic [31:0] s_dat_i = '0, rdat = '0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0] s_sel_o;
  logic [1:0] grant_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_we_o, timeout_o;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic m0c, m1c, ack;
    logic [1:0] g;
    logic sc, a0, a1;
  } vec_t;
  vec_t v[19];
  bexkat1_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_we_i(1'b0), .m0_adr_i(A0), .m0_dat_i(D0), .m0_sel_i(S0),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_we_i(1'b1), .m1_adr_i(A1), .m1_dat_i(D1), .m1_sel_i(S1),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #100000;
    $display("FAIL time_limit act=%0t req=<100000", $time);
    $fatal(1, "time limit");
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h at %0t", n, act, req, $time);
    end
  endtask
  task automatic drv(input logic m0c, input logic m1c, input logic ack);
    @(negedge clk_i);
    m0_cyc_i = m0c;
    m1_cyc_i = m1c;
    s_ack_i = ack;
    rdat = $urandom;
    s_dat_i = rdat;
  endtask
  task automatic expect_out(input string n, input logic [1:0] g, input logic sc, input logic a0,
                            input logic a1, input logic e0, input logic e1, input logic to);
    #2;
    chk({n, ".grant"}, 32'(grant_o), 32'(g));
    chk({n, ".s_cyc"}, 32'(s_cyc_o), 32'(sc));
    chk({n, ".m0_ack"}, 32'(m0_ack_o), 32'(a0));
    chk({n, ".m1_ack"}, 32'(m1_ack_o), 32'(a1));
    chk({n, ".m0_err"}, 32'(m0_err_o), 32'(e0));
    chk({n, ".m1_err"}, 32'(m1_err_o), 32'(e1));
    chk({n, ".timeout"}, 32'(timeout_o), 32'(to));
    chk({n, ".m0_dat"}, m0_dat_o, rdat);
    chk({n, ".m1_dat"}, m1_dat_o, rdat);
    if (sc) begin
      chk({n, ".s_adr"}, s_adr_o, g[1] ? A1 : A0);
      chk({n, ".s_dat"}, s_dat_o, g[1] ? D1 : D0);
      chk({n, ".s_sel"}, 32'(s_sel_o), 32'(g[1] ? S1 : S0));
      chk({n, ".s_we"}, 32'(s_we_o), 32'(g[1]));
    end
    if (g != 2'b10) begin
      checks++;
      if (s_dat_o == D1 || s_sel_o == S1) begin
        errors++;
        $display("FAIL %s.m1_leak act=%h/%h req=not %h/%h", n, s_dat_o, s_sel_o, D1, S1);
      end
    end
  endtask
  task automatic expect_zero(input string n);
    expect_out(n, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({n, ".s_adr0"}, s_adr_o, 32'h0);
    chk({n, ".s_dat0"}, s_dat_o, 32'h0);
    chk({n, ".s_sel0"}, 32'(s_sel_o), 32'h0);
    chk({n, ".s_we0"}, 32'(s_we_o), 32'h0);
  endtask
  initial begin
    v = '{8'b110_00_000, 8'b111_01_110, 8'b010_01_000, 8'b110_00_000, 8'b111_10_101,
          8'b100_10_000, 8'b110_00_000, 8'b111_01_110, 8'b010_01_000, 8'b010_00_000,
          8'b011_10_101, 8'b000_10_000, 8'b000_00_000, 8'b100_00_000, 8'b100_01_100,
          8'b100_01_100, 8'b101_01_110, 8'b000_01_000, 8'b000_00_000};
    drv(1'b1, 1'b1, 1'b0);
    expect_zero("reset_a");
    drv(1'b1, 1'b1, 1'b1);
    expect_zero("reset_b");
    drv(1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    expect_zero("reset_release");
    for (int i = 0; i < 19; i++) begin
      drv(v[i].m0c, v[i].m1c, v[i].ack);
      expect_out($sformatf("vec%0d", i), v[i].g, v[i].sc, v[i].a0, v[i].a1, 1'b0, 1'b0, 1'b0);
    end
    drv(1'b1, 1'b1, 1'b0);
    expect_out("lock_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      drv(1'b1, 1'b1, 1'b0);
      expect_out("lock_wait", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 1'b1, 1'b1);
      expect_out("lock_beat", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drv(1'b1, 1'b0, 1'b0);
    expect_out("lock_drop", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    expect_out("lock_dead", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      drv(1'b1, 1'b1, 1'b0);
      expect_out($sformatf("wd_busy%0d", c), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drv(1'b1, 1'b1, 1'b1);
    expect_out("wd_err", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b1);
    expect_out("wd_hold", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0);
    expect_out("wd_release", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0);
    expect_out("wd_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b1);
    expect_out("wd_m1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b1);
    #1 rst_i = 1'b0;
    expect_zero("rst_mid");
    drv(1'b1, 1'b1, 1'b1);
    expect_zero("rst_hold");
    drv(1'b1, 1'b1, 1'b0);
    rst_i = 1'b1;
    expect_out("post_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b1);
    expect_out("post_grant", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
